traffic_light_multi: RTL and testbench

// - N-phase intersection controller; successor to the fixed two-way light controller.
// - Serves N_PHASES approaches round-robin: GREEN -> YELLOW -> ALL_RED -> next phase.
// - Adds demand-actuated phase skipping (latched per-phase requests) and a night/fault FLASH mode.
// - Sits between the request-detector logic (loops/buttons, already synchronised to clk) and the lamp drivers.

---
 rtl/traffic_light_pkg.sv | 41 ++++
 rtl/traffic_light_multi_chk.sv | 31 +++
 rtl/traffic_phase_arb.sv | 42 ++++
 rtl/traffic_light_multi.sv | 228 ++++++++++++++++++++++
 tb/tb_traffic_light_multi.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg
//   Shared definitions for the N-phase intersection controller:
//   - one-hot state encodings and the controller state type
//   - default timing constants for a 16 MHz clock
//   - clog2_safe: index width helper that never returns zero
package traffic_light_pkg;

  // One-hot state encodings. A single flipped bit never aliases another
  // legal state.
  localparam logic [3:0] ST_GREEN_ENC   = 4'b0001;
  localparam logic [3:0] ST_YELLOW_ENC  = 4'b0010;
  localparam logic [3:0] ST_ALL_RED_ENC = 4'b0100;
  localparam logic [3:0] ST_FLASH_ENC   = 4'b1000;

  typedef enum logic [3:0] {
    ST_GREEN   = ST_GREEN_ENC,
    ST_YELLOW  = ST_YELLOW_ENC,
    ST_ALL_RED = ST_ALL_RED_ENC,
    ST_FLASH   = ST_FLASH_ENC
  } tl_state_e;

  // Default timing at 16 MHz: 30 s green, 5 s yellow, 2 s clearance,
  // 0.5 s flash half-period.
  localparam int DEF_N_PHASES          = 4;
  localparam int DEF_GREEN_CYCLES      = 480_000_000;
  localparam int DEF_YELLOW_CYCLES     = 80_000_000;
  localparam int DEF_ALLRED_CYCLES     = 32_000_000;
  localparam int DEF_FLASH_HALF_CYCLES = 8_000_000;
  localparam int DEF_CNT_W             = 32;

  // Width of an index into n items. Returns at least 1 so that a
  // two-phase build still gets a one-bit phase index.
  function automatic int clog2_safe(input int n);
    if (n <= 2) begin
      clog2_safe = 1;
    end else begin
      clog2_safe = $clog2(n);
    end
  endfunction

endpackage

// File: rtl/traffic_light_multi_chk.sv
// traffic_light_multi_chk
//   Lamp-safety invariants for traffic_light_multi, evaluated on every
//   clock edge outside reset.
// Ports
//   clk, rst_n               clock and active-low reset of the controller
//   red, yellow, green       lamp outputs being checked
//   in_flash                 flash-mode indicator
module traffic_light_multi_chk #(
  parameter int N_PHASES = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic [N_PHASES-1:0] red,
  input logic [N_PHASES-1:0] yellow,
  input logic [N_PHASES-1:0] green,
  input logic                in_flash
);

  // Never more than one approach showing a proceed/caution aspect.
  a_one_active: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(green | yellow) <= 1);

  // The active approach is never red at the same time.
  a_active_not_red: assert property (@(posedge clk) disable iff (!rst_n)
    ((green | yellow) & red) == {N_PHASES{1'b0}});

  // Flash mode drives only the red lamps.
  a_flash_dark: assert property (@(posedge clk) disable iff (!rst_n)
    in_flash |-> ((green | yellow) == {N_PHASES{1'b0}}));

endmodule

// File: rtl/traffic_phase_arb.sv
// traffic_phase_arb
//   Combinational round-robin finder. Searches demand starting at
//   phase+1, wrapping modulo N_PHASES, and checks phase itself last.
// Ports
//   demand     in  N_PHASES  latched per-phase demand
//   phase      in  PH_W      phase that was granted green last
//   next_phase out PH_W      first demanding phase after phase (phase if none)
//   any_demand out 1         at least one demand bit is set
module traffic_phase_arb
  import traffic_light_pkg::*;
#(
  parameter int N_PHASES = DEF_N_PHASES,
  parameter int PH_W     = clog2_safe(N_PHASES)
) (
  input  logic [N_PHASES-1:0] demand,
  input  logic [PH_W-1:0]     phase,
  output logic [PH_W-1:0]     next_phase,
  output logic                any_demand
);

  logic            found_s;
  logic [PH_W-1:0] idx_s;

  // Walk offsets 1..N_PHASES so that phase itself is the last candidate.
  always_comb begin
    found_s    = 1'b0;
    idx_s      = phase;
    next_phase = phase;
    for (int k = 1; k <= N_PHASES; k++) begin
      idx_s = PH_W'((int'(phase) + k) % N_PHASES);
      if (!found_s && demand[idx_s]) begin
        next_phase = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s    = found_s;
      end
    end
  end

  assign any_demand = |demand;

endmodule

// File: rtl/traffic_light_multi.sv
// traffic_light_multi
//   N-phase intersection controller. Serves approaches round-robin
//   (GREEN -> YELLOW -> ALL_RED -> next phase), skips phases without a
//   latched request and supports a night/fault FLASH mode.
// Ports
//   clk       in   1         system clock
//   rst_n     in   1         asynchronous active-low reset
//   req       in   N_PHASES  per-phase demand (level or 1-cycle pulse)
//   flash     in   1         request flash mode
//   red       out  N_PHASES  red lamps, registered
//   yellow    out  N_PHASES  yellow lamps, registered
//   green     out  N_PHASES  green lamps, registered
//   phase     out  PH_W      last phase granted green
//   in_flash  out  1         controller is in FLASH
module traffic_light_multi
  import traffic_light_pkg::*;
#(
  parameter int N_PHASES          = DEF_N_PHASES,
  parameter int GREEN_CYCLES      = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES     = DEF_YELLOW_CYCLES,
  parameter int ALLRED_CYCLES     = DEF_ALLRED_CYCLES,
  parameter int FLASH_HALF_CYCLES = DEF_FLASH_HALF_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_PHASES-1:0]                req,
  input  logic                               flash,
  output logic [N_PHASES-1:0]                red,
  output logic [N_PHASES-1:0]                yellow,
  output logic [N_PHASES-1:0]                green,
  output logic [clog2_safe(N_PHASES)-1:0]    phase,
  output logic                               in_flash
);

  localparam int PH_W = clog2_safe(N_PHASES);

  localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]    YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]    ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0]    FLASH_LAST  = CNT_W'(FLASH_HALF_CYCLES - 1);
  localparam logic [N_PHASES-1:0] LAMPS_OFF   = {N_PHASES{1'b0}};
  localparam logic [N_PHASES-1:0] LAMPS_ON    = {N_PHASES{1'b1}};
  localparam logic [N_PHASES-1:0] PH_ONE      = {{(N_PHASES-1){1'b0}}, 1'b1};
  localparam logic [PH_W-1:0]     PH_RESET    = PH_W'(N_PHASES - 1);

  tl_state_e           state_r,  state_nx_s;
  logic [CNT_W-1:0]    cnt_r,    cnt_nx_s;
  logic [N_PHASES-1:0] demand_r, demand_nx_s;
  logic [PH_W-1:0]     phase_r,  phase_nx_s;
  logic                lamp_r,   lamp_nx_s;
  logic                enter_green_s;
  logic [N_PHASES-1:0] green_mask_s, clr_mask_s, sel_nx_s;
  logic [PH_W-1:0]     arb_phase_s;
  logic                any_demand_s;

  logic [N_PHASES-1:0] red_r,    red_nx_s;
  logic [N_PHASES-1:0] yellow_r, yellow_nx_s;
  logic [N_PHASES-1:0] green_r,  green_nx_s;
  logic                in_flash_r, in_flash_nx_s;

  traffic_phase_arb #(
    .N_PHASES (N_PHASES),
    .PH_W     (PH_W)
  ) u_arb (
    .demand     (demand_r),
    .phase      (phase_r),
    .next_phase (arb_phase_s),
    .any_demand (any_demand_s)
  );

  // Next state, timer, granted phase and flash lamp phase.
  always_comb begin
    state_nx_s    = state_r;
    cnt_nx_s      = cnt_r;
    phase_nx_s    = phase_r;
    lamp_nx_s     = lamp_r;
    enter_green_s = 1'b0;
    case (state_r)
      ST_GREEN: begin
        // flash cuts green short but still goes through yellow
        if (flash || (cnt_r == GREEN_LAST)) begin
          state_nx_s = ST_YELLOW;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end
      ST_YELLOW: begin
        if (cnt_r == YELLOW_LAST) begin
          state_nx_s = ST_ALL_RED;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end
      ST_ALL_RED: begin
        // After expiry the counter parks on ALLRED_LAST, so a dwelling
        // controller re-evaluates flash and demand on every cycle.
        if (cnt_r != ALLRED_LAST) begin
          cnt_nx_s      = cnt_r + CNT_ONE;
        end else if (flash) begin
          state_nx_s    = ST_FLASH;
          cnt_nx_s      = CNT_ZERO;
          lamp_nx_s     = 1'b1;
        end else if (any_demand_s) begin
          state_nx_s    = ST_GREEN;
          cnt_nx_s      = CNT_ZERO;
          phase_nx_s    = arb_phase_s;
          enter_green_s = 1'b1;
        end else begin
          cnt_nx_s      = cnt_r;
        end
      end
      ST_FLASH: begin
        if (!flash) begin
          state_nx_s = ST_ALL_RED;
          cnt_nx_s   = CNT_ZERO;
        end else if (cnt_r == FLASH_LAST) begin
          lamp_nx_s  = ~lamp_r;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        // Illegal encoding: fall back to a full clearance.
        state_nx_s = ST_ALL_RED;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Demand latch: the phase currently green ignores its own request, and
  // the grant clears the winning bit even if it is requested again.
  always_comb begin
    if (state_r == ST_GREEN) begin
      green_mask_s = PH_ONE << phase_r;
    end else begin
      green_mask_s = LAMPS_OFF;
    end
    if (enter_green_s) begin
      clr_mask_s = PH_ONE << phase_nx_s;
    end else begin
      clr_mask_s = LAMPS_OFF;
    end
    demand_nx_s = (demand_r | (req & ~green_mask_s)) & ~clr_mask_s;
  end

  // Lamp decode from the next state so the registered lamps change on the
  // same edge as the state.
  always_comb begin
    sel_nx_s      = PH_ONE << phase_nx_s;
    red_nx_s      = LAMPS_ON;
    yellow_nx_s   = LAMPS_OFF;
    green_nx_s    = LAMPS_OFF;
    in_flash_nx_s = 1'b0;
    case (state_nx_s)
      ST_GREEN: begin
        green_nx_s  = sel_nx_s;
        red_nx_s    = ~sel_nx_s;
      end
      ST_YELLOW: begin
        yellow_nx_s = sel_nx_s;
        red_nx_s    = ~sel_nx_s;
      end
      ST_ALL_RED: begin
        red_nx_s    = LAMPS_ON;
      end
      ST_FLASH: begin
        in_flash_nx_s = 1'b1;
        if (lamp_nx_s) begin
          red_nx_s = LAMPS_ON;
        end else begin
          red_nx_s = LAMPS_OFF;
        end
      end
      default: begin
        red_nx_s = LAMPS_ON;
      end
    endcase
  end

  // Controller state, timer, demand and lamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ALL_RED;
      cnt_r      <= CNT_ZERO;
      demand_r   <= LAMPS_OFF;
      phase_r    <= PH_RESET;
      lamp_r     <= 1'b1;
      red_r      <= LAMPS_ON;
      yellow_r   <= LAMPS_OFF;
      green_r    <= LAMPS_OFF;
      in_flash_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      demand_r   <= demand_nx_s;
      phase_r    <= phase_nx_s;
      lamp_r     <= lamp_nx_s;
      red_r      <= red_nx_s;
      yellow_r   <= yellow_nx_s;
      green_r    <= green_nx_s;
      in_flash_r <= in_flash_nx_s;
    end
  end

  assign red      = red_r;
  assign yellow   = yellow_r;
  assign green    = green_r;
  assign phase    = phase_r;
  assign in_flash = in_flash_r;

  traffic_light_multi_chk #(
    .N_PHASES (N_PHASES)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .red      (red_r),
    .yellow   (yellow_r),
    .green    (green_r),
    .in_flash (in_flash_r)
  );

endmodule

// File: tb/tb_traffic_light_multi.sv
// tb_traffic_light_multi
//   Self-checking bench for traffic_light_multi with short timing
//   (4 phases, green 10, yellow 3, clearance 2, flash half-period 4).
//   Table-driven directed sequences, hand-written corner cases and a
//   randomized run against a countdown-based reference model.
module tb_traffic_light_multi;

  localparam int NP = 4;
  localparam int GC = 10;
  localparam int YC = 3;
  localparam int AC = 2;
  localparam int FH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic       flash = 1'b0;
  logic [3:0] red, yellow, green;
  logic [1:0] phase;
  logic       in_flash;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_light_multi #(
    .N_PHASES          (NP),
    .GREEN_CYCLES      (GC),
    .YELLOW_CYCLES     (YC),
    .ALLRED_CYCLES     (AC),
    .FLASH_HALF_CYCLES (FH),
    .CNT_W             (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .flash    (flash),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .phase    (phase),
    .in_flash (in_flash)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given inputs, release away from an edge, check reset state.
  task automatic do_reset(input logic [3:0] rq, input logic fl);
    rst_n = 1'b0;
    req   = rq;
    flash = fl;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("rst_red",    int'(red),          int'(4'hF));
    chk("rst_yellow", int'(yellow),       int'(4'h0));
    chk("rst_green",  int'(green),        int'(4'h0));
    chk("rst_phase",  int'(phase),        3);
    chk("rst_flash",  int'(in_flash),     0);
    chk("rst_demand", int'(dut.demand_r), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int rst;
    int req;
    int flash;
    int n;
    int red;
    int yel;
    int grn;
    int ph;
    int inf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, input int rq, input int fl, input int n,
                     input int rd, input int yl, input int gr, input int ph,
                     input int inf);
    vec_t v;
    v.rst = r;  v.req = rq; v.flash = fl; v.n = n;
    v.red = rd; v.yel = yl; v.grn = gr;   v.ph = ph; v.inf = inf;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 clearance, 1 green, 2 yellow, 3 flash; left = cycles remaining
  int m_mode;
  int m_left;
  int m_phase;
  bit m_lamp;
  bit m_dem [NP];

  task automatic model_reset();
    m_mode  = 0;
    m_left  = AC;
    m_phase = NP - 1;
    m_lamp  = 1'b1;
    for (int i = 0; i < NP; i++) m_dem[i] = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] rq, input logic fl);
    int tgt;
    int old_mode;
    int old_ph;
    int cand;
    tgt      = -1;
    old_mode = m_mode;
    old_ph   = m_phase;
    case (m_mode)
      0: begin
        if (m_left > 1) m_left--;
        else if (fl) begin
          m_mode = 3; m_left = FH; m_lamp = 1'b1;
        end else begin
          for (int k = 1; k <= NP; k++) begin
            cand = (m_phase + k) % NP;
            if (tgt < 0 && m_dem[cand]) tgt = cand;
          end
          if (tgt >= 0) begin
            m_mode = 1; m_left = GC; m_phase = tgt;
          end
        end
      end
      1: begin
        if (fl || m_left == 1) begin m_mode = 2; m_left = YC; end
        else m_left--;
      end
      2: begin
        if (m_left == 1) begin m_mode = 0; m_left = AC; end
        else m_left--;
      end
      default: begin
        if (!fl) begin m_mode = 0; m_left = AC; end
        else if (m_left == 1) begin m_lamp = ~m_lamp; m_left = FH; end
        else m_left--;
      end
    endcase
    for (int i = 0; i < NP; i++)
      if (rq[i] && !(old_mode == 1 && old_ph == i)) m_dem[i] = 1'b1;
    if (tgt >= 0) m_dem[tgt] = 1'b0;
  endtask

  function automatic int model_out();
    logic [3:0] r, y, g, sel;
    logic       inf;
    sel = 4'b0001 << m_phase;
    r = 4'hF; y = 4'h0; g = 4'h0; inf = 1'b0;
    case (m_mode)
      1: begin g = sel; r = ~sel; end
      2: begin y = sel; r = ~sel; end
      3: begin inf = 1'b1; r = m_lamp ? 4'hF : 4'h0; end
      default: r = 4'hF;
    endcase
    return int'({r, y, g, 2'(m_phase), inf});
  endfunction

  int         seq[$];
  logic [3:0] prev_green;
  bit         found;

  initial begin
    // T1: all requests held, order 0,1,2,3,0
    add(1, 15, 0,  1, 'hF, 0, 0, 3, 0);
    add(0, 15, 0, 10, 'hE, 0, 1, 0, 0);
    add(0, 15, 0,  3, 'hE, 1, 0, 0, 0);
    add(0, 15, 0,  2, 'hF, 0, 0, 0, 0);
    add(0, 15, 0, 10, 'hD, 0, 2, 1, 0);
    add(0, 15, 0,  3, 'hD, 2, 0, 1, 0);
    add(0, 15, 0,  2, 'hF, 0, 0, 1, 0);
    add(0, 15, 0, 10, 'hB, 0, 4, 2, 0);
    add(0, 15, 0,  3, 'hB, 4, 0, 2, 0);
    add(0, 15, 0,  2, 'hF, 0, 0, 2, 0);
    add(0, 15, 0, 10, 'h7, 0, 8, 3, 0);
    add(0, 15, 0,  3, 'h7, 8, 0, 3, 0);
    add(0, 15, 0,  2, 'hF, 0, 0, 3, 0);
    add(0, 15, 0,  1, 'hE, 0, 1, 0, 0);
    // T4: flash at cnt=4 of green[0]; T5: release with demand[2] pending
    add(1,  1, 0,  1, 'hF, 0, 0, 3, 0);
    add(0,  1, 0,  1, 'hE, 0, 1, 0, 0);
    add(0,  0, 0,  4, 'hE, 0, 1, 0, 0);
    add(0,  0, 1,  3, 'hE, 1, 0, 0, 0);
    add(0,  0, 1,  2, 'hF, 0, 0, 0, 0);
    add(0,  4, 1,  1, 'hF, 0, 0, 0, 1);
    add(0,  0, 1,  3, 'hF, 0, 0, 0, 1);
    add(0,  0, 1,  4, 'h0, 0, 0, 0, 1);
    add(0,  0, 1,  4, 'hF, 0, 0, 0, 1);
    add(0,  0, 0,  2, 'hF, 0, 0, 0, 0);
    add(0,  0, 0,  1, 'hB, 0, 4, 2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst != 0) begin
        do_reset(4'(tbl[i].req), tbl[i].flash != 0);
      end else begin
        req   = 4'(tbl[i].req);
        flash = (tbl[i].flash != 0);
      end
      for (int c = 0; c < tbl[i].n; c++) begin
        tick();
        chk($sformatf("vec%0d.%0d_red", i, c),    int'(red),      tbl[i].red);
        chk($sformatf("vec%0d.%0d_yellow", i, c), int'(yellow),   tbl[i].yel);
        chk($sformatf("vec%0d.%0d_green", i, c),  int'(green),    tbl[i].grn);
        chk($sformatf("vec%0d.%0d_phase", i, c),  int'(phase),    tbl[i].ph);
        chk($sformatf("vec%0d.%0d_flash", i, c),  int'(in_flash), tbl[i].inf);
      end
    end
    chk("t5_demand_cleared", int'(dut.demand_r), 0);

    // T2: single pulse on req[2] while dwelling in clearance
    do_reset(4'b0000, 1'b0);
    tick(); tick(); tick();
    chk("t2_dwell_red",   int'(red),   int'(4'hF));
    chk("t2_dwell_green", int'(green), 0);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    chk("t2_latched_green",  int'(green),        0);
    chk("t2_latched_demand", int'(dut.demand_r), int'(4'b0100));
    tick();
    chk("t2_green",  int'(green),        int'(4'b0100));
    chk("t2_red",    int'(red),          int'(4'b1011));
    chk("t2_phase",  int'(phase),        2);
    chk("t2_demand", int'(dut.demand_r), 0);

    // T3: req[1] held, req[3] pulsed during green[1] -> 1,3,1
    do_reset(4'b0010, 1'b0);
    seq.delete();
    prev_green = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      req = (c == 4) ? 4'b1010 : 4'b0010;
      tick();
      chk($sformatf("t3_exclusive_%0d", c), int'($countones(green | yellow) <= 1), 1);
      if (green != 4'b0000 && prev_green == 4'b0000) seq.push_back(int'(phase));
      prev_green = green;
    end
    chk("t3_grants", seq.size(), 3);
    chk("t3_first",  (seq.size() > 0) ? seq[0] : -1, 1);
    chk("t3_second", (seq.size() > 1) ? seq[1] : -1, 3);
    chk("t3_third",  (seq.size() > 2) ? seq[2] : -1, 1);

    // T6: asynchronous reset in the middle of yellow[1]
    do_reset(4'b1111, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (yellow == 4'b0010) found = 1'b1;
    end
    chk("t6_reach_yellow1", int'(found), 1);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_red",    int'(red),          int'(4'hF));
    chk("t6_async_yellow", int'(yellow),       0);
    chk("t6_async_green",  int'(green),        0);
    chk("t6_async_demand", int'(dut.demand_r), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_restart_red", int'(red), int'(4'hF));
    tick();
    chk("t6_restart_green", int'(green), int'(4'b0001));
    chk("t6_restart_phase", int'(phase), 0);

    // Randomized run against the reference model
    do_reset(4'b0000, 1'b0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      req = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 79) == 0) flash = ~flash;
      @(posedge clk);
      model_step(req, flash);
      #1;
      chk($sformatf("rnd_%0d", c),
          int'({red, yellow, green, phase, in_flash}), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
